ifetch_unit: RTL and testbench

- Instruction fetch stage and initiator on the instruction-memory port.
- Holds the architectural fetch PC and drives the PC address to the instruction memory.
- Captures the returned instruction or access fault into a registered output slot, and hands it to decode over a valid/ready handshake.
- Handles redirects (branch/jump/trap) and parks after emitting a fetch exception until redirected.

---
 rtl/ifetch_unit.sv | 92 +++++++++
 tb/tb_ifetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the fetch PC, drives it to instruction memory and
// registers the returned word or access fault into a single valid/ready output slot.
module ifetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic [63:0] imem_pc_addr,
  input  logic [31:0] imem_instruction,
  input  logic        imem_exc_en,
  input  logic [3:0]  imem_exc_code,
  input  logic [63:0] imem_exc_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc_en,
  output logic [3:0]  out_exc_code,
  output logic [63:0] out_exc_val,
  output logic [63:0] fetch_count
);

  typedef enum logic [0:0] {FETCH, PARKED} state_t;

  state_t      state;
  logic [63:0] pc;
  logic        accept;
  logic        load;
  logic        mis;
  logic        fault;

  // Memory address comes straight from the PC register; no input reaches it combinationally.
  assign imem_pc_addr = pc;

  assign accept = out_valid && out_ready;
  assign load   = (state == FETCH) && (!out_valid || out_ready);
  assign mis    = pc[1:0] != 2'b00;
  assign fault  = mis || imem_exc_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      out_valid    <= 1'b0;
      out_pc       <= 64'd0;
      out_instr    <= NOP_INSTR;
      out_exc_en   <= 1'b0;
      out_exc_code <= 4'd0;
      out_exc_val  <= 64'd0;
      fetch_count  <= 64'd0;
    end else begin
      // A handshake counts even when a redirect flushes the slot in the same cycle.
      if (accept) fetch_count <= fetch_count + 64'd1;

      if (redirect_en) begin
        pc         <= redirect_pc;
        out_valid  <= 1'b0;
        out_exc_en <= 1'b0;
        state      <= FETCH;
      end else begin
        case (state)
          FETCH: begin
            if (load) begin
              out_valid <= 1'b1;
              out_pc    <= pc;
              if (fault) begin
                // Misalignment wins over a memory fault; stay parked until redirected.
                out_instr    <= NOP_INSTR;
                out_exc_en   <= 1'b1;
                out_exc_code <= mis ? 4'd0 : imem_exc_code;
                out_exc_val  <= mis ? pc : imem_exc_val;
                state        <= PARKED;
              end else begin
                out_instr  <= imem_instruction;
                out_exc_en <= 1'b0;
                pc         <= pc + 64'd4;
              end
            end
          end
          PARKED: begin
            if (accept) out_valid <= 1'b0;
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: the bench plays instruction memory, keeps a
// transaction-level model of the fetch stream and checks the DUT every cycle.
module tb_ifetch_unit;

  localparam logic [63:0] RESET_PC  = 64'h0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic [63:0] imem_pc_addr;
  logic [31:0] imem_instruction;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc_en;
  logic [3:0]  out_exc_code;
  logic [63:0] out_exc_val;
  logic [63:0] fetch_count;

  int checks = 0;
  int errors = 0;

  // memory fault knobs
  logic        exc_armed = 1'b0;
  logic        exc_force = 1'b0;
  logic [63:0] exc_pc    = 64'h0;
  logic [3:0]  exc_code  = 4'd0;
  logic [63:0] exc_val   = 64'h0;

  ifetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_pc_addr(imem_pc_addr), .imem_instruction(imem_instruction),
    .imem_exc_en(imem_exc_en), .imem_exc_code(imem_exc_code), .imem_exc_val(imem_exc_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_exc_en(out_exc_en), .out_exc_code(out_exc_code), .out_exc_val(out_exc_val),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [63:0] a);
    case (a)
      64'h0:   memword = 32'h0050_0093;
      64'h4:   memword = 32'h0010_0113;
      64'h8:   memword = 32'h0020_81b3;
      default: memword = a[31:0] ^ 32'h5A5A_0003;
    endcase
  endfunction

  function automatic logic exc_at(input logic [63:0] a);
    exc_at = exc_force || (exc_armed && a == exc_pc);
  endfunction

  assign imem_instruction = memword(imem_pc_addr);
  assign imem_exc_en      = exc_at(imem_pc_addr);
  assign imem_exc_code    = exc_code;
  assign imem_exc_val     = exc_val;

  // Transaction-level model: what decode should see and where fetch should be.
  logic        started = 1'b0;
  logic [63:0] m_pc, m_opc, m_val, m_cnt;
  logic [31:0] m_instr;
  logic [3:0]  m_code;
  logic        m_valid, m_exc, m_parked;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      m_pc = RESET_PC; m_valid = 1'b0; m_opc = 64'h0; m_instr = NOP_INSTR;
      m_exc = 1'b0; m_code = 4'd0; m_val = 64'h0; m_cnt = 64'h0; m_parked = 1'b0;
    end else begin
      logic taken;
      taken = m_valid && out_ready;
      if (taken) m_cnt = m_cnt + 64'd1;
      if (redirect_en) begin
        m_pc = redirect_pc; m_valid = 1'b0; m_exc = 1'b0; m_parked = 1'b0;
      end else if (m_parked) begin
        if (taken) m_valid = 1'b0;
      end else if (!m_valid || taken) begin
        m_valid = 1'b1;
        m_opc   = m_pc;
        if (m_pc[1:0] != 2'b00) begin
          m_instr = NOP_INSTR; m_exc = 1'b1; m_code = 4'd0; m_val = m_pc; m_parked = 1'b1;
        end else if (exc_at(m_pc)) begin
          m_instr = NOP_INSTR; m_exc = 1'b1; m_code = exc_code; m_val = exc_val; m_parked = 1'b1;
        end else begin
          m_instr = memword(m_pc); m_exc = 1'b0; m_pc = m_pc + 64'd4;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("m.imem_pc_addr", imem_pc_addr, m_pc);
      chk("m.out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      chk("m.fetch_count", fetch_count, m_cnt);
      chk("m.out_exc_en", {63'd0, out_exc_en}, {63'd0, m_exc});
      if (m_valid) begin
        chk("m.out_pc", out_pc, m_opc);
        chk("m.out_instr", {32'd0, out_instr}, {32'd0, m_instr});
        if (m_exc) begin
          chk("m.out_exc_code", {60'd0, out_exc_code}, {60'd0, m_code});
          chk("m.out_exc_val", out_exc_val, m_val);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; redirect_en = 1'b0; redirect_pc = 64'h0; out_ready = 1'b1;
    step(2);
    chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst.imem_pc_addr", imem_pc_addr, RESET_PC);
    chk("rst.out_instr", {32'd0, out_instr}, 64'h13);
    chk("rst.fetch_count", fetch_count, 64'd0);
    rst = 1'b0;

    // 1: streaming at one per cycle
    step(1);
    chk("t1.out_pc0", out_pc, 64'h0);
    chk("t1.instr0", {32'd0, out_instr}, 64'h0050_0093);
    step(1);
    chk("t1.out_pc4", out_pc, 64'h4);
    chk("t1.instr4", {32'd0, out_instr}, 64'h0010_0113);
    step(1);
    chk("t1.out_pc8", out_pc, 64'h8);

    // 2: stall three cycles on pc 8
    out_ready = 1'b0;
    step(3);
    chk("t2.hold_pc", out_pc, 64'h8);
    chk("t2.hold_instr", {32'd0, out_instr}, 64'h0020_81b3);
    chk("t2.imem_addr", imem_pc_addr, 64'hC);
    out_ready = 1'b1;
    step(1);
    chk("t2.next_pc", out_pc, 64'hC);
    chk("t1.count3", fetch_count, 64'd3);
    step(1);
    chk("t3.at_10", out_pc, 64'h10);

    // 3: redirect while the slot at 0x10 is being accepted
    redirect_en = 1'b1; redirect_pc = 64'h100;
    step(1);
    redirect_en = 1'b0;
    chk("t3.flush", {63'd0, out_valid}, 64'd0);
    chk("t3.addr", imem_pc_addr, 64'h100);
    chk("t3.count", fetch_count, 64'd5);
    step(1);
    chk("t3.first", out_pc, 64'h100);

    // 4: access fault at 0x2000, then parked until redirect
    exc_armed = 1'b1; exc_pc = 64'h2000; exc_code = 4'd1; exc_val = 64'h2000;
    redirect_en = 1'b1; redirect_pc = 64'h2000;
    step(1);
    redirect_en = 1'b0;
    step(1);
    chk("t4.exc_en", {63'd0, out_exc_en}, 64'd1);
    chk("t4.code", {60'd0, out_exc_code}, 64'd1);
    chk("t4.val", out_exc_val, 64'h2000);
    chk("t4.instr", {32'd0, out_instr}, 64'h13);
    step(1);
    exc_armed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4.parked", {63'd0, out_valid}, 64'd0);
      step(1);
    end
    redirect_en = 1'b1; redirect_pc = 64'h0;
    step(1);
    redirect_en = 1'b0;
    step(2);
    chk("t4.resume", out_pc, 64'h4);

    // fault slot held under back-pressure, tval differs from pc
    exc_armed = 1'b1; exc_pc = 64'h3000; exc_code = 4'd5; exc_val = 64'h3004;
    redirect_en = 1'b1; redirect_pc = 64'h3000;
    step(1);
    redirect_en = 1'b0; out_ready = 1'b0;
    step(3);
    chk("t4b.val", out_exc_val, 64'h3004);
    chk("t4b.code", {60'd0, out_exc_code}, 64'd5);
    out_ready = 1'b1;
    step(1);
    exc_armed = 1'b0;

    // 5: misaligned redirect beats a same-cycle memory fault
    exc_force = 1'b1; exc_code = 4'd7; exc_val = 64'hDEAD;
    redirect_en = 1'b1; redirect_pc = 64'h102;
    step(1);
    redirect_en = 1'b0;
    step(1);
    chk("t5.exc_en", {63'd0, out_exc_en}, 64'd1);
    chk("t5.code", {60'd0, out_exc_code}, 64'd0);
    chk("t5.val", out_exc_val, 64'h102);
    step(3);
    chk("t5.parked", {63'd0, out_valid}, 64'd0);
    exc_force = 1'b0;

    // 6: reset during a stall
    redirect_en = 1'b1; redirect_pc = 64'h40;
    step(1);
    redirect_en = 1'b0; out_ready = 1'b0;
    step(3);
    chk("t6.stall_pc", out_pc, 64'h40);
    rst = 1'b1;
    step(1);
    chk("t6.valid", {63'd0, out_valid}, 64'd0);
    chk("t6.addr", imem_pc_addr, RESET_PC);
    chk("t6.count", fetch_count, 64'd0);
    rst = 1'b0; out_ready = 1'b1;
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
